fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_inc.sv | 15 +
 rtl/fetch_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the instruction fetch controller.
//   fetch_state_t : fetch FSM state encoding
//   INSTR_BYTES   : byte distance between sequential instructions
//   KILL_W        : width of the discarded-fetch counter
package pc_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned KILL_W      = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        KILL = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/pc_inc.sv
// Sequential program-counter increment (pc + one instruction, wraps modulo 2^WIDTH).
//   pc      in  WIDTH  current program counter
//   pc_next out WIDTH  address of the next sequential instruction
module pc_inc
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next
);

    assign pc_next = pc + WIDTH'(INSTR_BYTES);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one memory read at a time, holds the
// returned word for decode, and handles redirects by discarding in-flight data.
//   clk, rst               clock, asynchronous active-low reset
//   redirect_valid/_pc     taken branch/jump and its target (low 2 bits ignored)
//   imem_req/_addr/_gnt    request handshake to instruction memory
//   imem_rvalid/_rdata     read response from instruction memory
//   if_valid/_pc/_instr    instruction presented to decode
//   if_ready               decode consumes when if_valid && if_ready
//   kill_count             saturating count of fetches discarded by a redirect
module fetch_ctrl
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_0000)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [WIDTH-1:0]    redirect_pc,
    output logic                imem_req,
    output logic [WIDTH-1:0]    imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [WIDTH-1:0]    imem_rdata,
    output logic                if_valid,
    output logic [WIDTH-1:0]    if_pc,
    output logic [WIDTH-1:0]    if_instr,
    input  logic                if_ready,
    output logic [KILL_W-1:0]   kill_count
);

    localparam logic [KILL_W-1:0] KILL_MAX = '1;

    fetch_state_t       state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [WIDTH-1:0]   instr_q, instr_d;
    logic [KILL_W-1:0]  kill_q, kill_d;
    logic               kill_inc;
    logic [WIDTH-1:0]   pc_seq;
    logic [WIDTH-1:0]   redirect_tgt;

    // Targets are always word aligned
    assign redirect_tgt = redirect_pc & ~WIDTH'(INSTR_BYTES - 1);

    pc_inc #(.WIDTH(WIDTH)) u_pc_inc (
        .pc      (pc_q),
        .pc_next (pc_seq)
    );

    // State, pc, holding register and kill counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            kill_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            kill_q  <= kill_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        kill_inc  = 1'b0;
        imem_req  = 1'b0;
        imem_addr = pc_q;
        if_valid  = 1'b0;
        if_pc     = pc_q;
        if_instr  = instr_q;

        unique case (state_q)
            IDLE: state_d = REQ;

            REQ: begin
                imem_req = 1'b1;
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                    // A grant in the redirect cycle fetched the stale pc
                    if (imem_gnt) begin
                        state_d  = KILL;
                        kill_inc = 1'b1;
                    end
                end else if (imem_gnt) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (redirect_valid) begin
                    pc_d     = redirect_tgt;
                    kill_inc = 1'b1;
                    state_d  = imem_rvalid ? REQ : KILL;
                end else if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end

            KILL: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end

            HOLD: begin
                if_valid = 1'b1;
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = REQ;
                end else if (if_ready) begin
                    pc_d    = pc_seq;
                    state_d = REQ;
                end
            end

            default: state_d = IDLE;
        endcase

        kill_d = (kill_inc && (kill_q != KILL_MAX)) ? kill_q + KILL_W'(1) : kill_q;
    end

    assign kill_count = kill_q;

endmodule
